// File: rtl/hamming_mem_engine.sv
// Hamming(16,11) SECDED encode/decode engine that streams N_MSG messages
// between two byte regions of a synchronous memory.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   req, mode         start pulse; 0 = encode, 1 = decode (latched on accept)
//   done              run complete, held until the next accepted req
//   mem_addr/wen      byte address and write enable
//   mem_wdata         write data
//   mem_rdata         read data, valid one cycle after mem_addr
//   sec_cnt, ded_cnt  single-corrected / double-detected counts (decode)
module hamming_mem_engine #(
    parameter int N_MSG    = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              mode,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        sec_cnt,
    output logic [7:0]        ded_cnt
);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, CAP, WR_LO, WR_HI, DONE
    } state_t;

    // Data bit i (d[i+1]) lives at codeword positions 3,5,6,7,9..15.
    function automatic logic [15:0] enc_cw(input logic [10:0] d);
        logic [15:0] c;
        logic        p;
        c        = '0;
        c[3]     = d[0];
        c[7:5]   = d[3:1];
        c[15:9]  = d[10:4];
        // Parity positions only carry their own index bit, so computing
        // them in order never folds an earlier parity into a later one.
        for (int k = 0; k < 4; k++) begin
            p = 1'b0;
            for (int j = 1; j < 16; j++) begin
                if (j[k]) p = p ^ c[j];
            end
            c[1 << k] = p;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [3:0] syndrome(input logic [15:0] c);
        logic [3:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 1; j < 16; j++) begin
                if (j[k]) s[k] = s[k] ^ c[j];
            end
        end
        return s;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] c);
        return {c[15:9], c[7:5], c[3]};
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic        mode_q, mode_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] res_q, res_d;
    logic [7:0]  sec_q, sec_d;
    logic [7:0]  ded_q, ded_d;
    logic        done_q, done_d;

    logic [15:0]       cw, cw_fix, cw_enc;
    logic [3:0]        syn;
    logic              par;
    logic [10:0]       dat;
    logic [1:0]        flags;
    logic [15:0]       dec_res;
    logic [ADDR_W-1:0] src_a, dst_a;

    // Datapath: high byte arrives on mem_rdata in CAP, low byte in lo_q.
    always_comb begin
        cw     = {mem_rdata, lo_q};
        cw_enc = enc_cw({mem_rdata[2:0], lo_q});
        syn    = syndrome(cw);
        par    = ^cw;
        cw_fix = cw;
        flags  = 2'b00;
        if (par) begin
            // S = 0 flips p0 only, which never reaches the data bits.
            cw_fix = cw ^ (16'd1 << syn);
            flags  = 2'b01;
        end else if (syn != 4'd0) begin
            flags  = 2'b10;
        end
        dat     = extract(cw_fix);
        dec_res = {flags, 3'b000, dat[10:8], dat[7:0]};
    end

    always_comb begin
        src_a = ADDR_W'(SRC_BASE) + ADDR_W'({idx_q, 1'b0});
        dst_a = ADDR_W'(DST_BASE) + ADDR_W'({idx_q, 1'b0});
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mode_d    = mode_q;
        lo_d      = lo_q;
        res_d     = res_q;
        sec_d     = sec_q;
        ded_d     = ded_q;
        done_d    = done_q;
        mem_addr  = ADDR_W'(SRC_BASE);
        mem_wen   = 1'b0;
        mem_wdata = res_q[7:0];
        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) done_d = 1'b1;
                if (req) begin
                    state_d = RD_LO;
                    done_d  = 1'b0;
                    idx_d   = '0;
                    sec_d   = '0;
                    ded_d   = '0;
                    mode_d  = mode;
                end
            end
            RD_LO: begin
                mem_addr = src_a;
                state_d  = RD_HI;
            end
            RD_HI: begin
                mem_addr = src_a + ADDR_W'(1);
                lo_d     = mem_rdata;
                state_d  = CAP;
            end
            CAP: begin
                mem_addr = src_a + ADDR_W'(1);
                state_d  = WR_LO;
                if (mode_q) begin
                    res_d = dec_res;
                    if (flags[0]) sec_d = sec_q + 8'd1;
                    if (flags[1]) ded_d = ded_q + 8'd1;
                end else begin
                    res_d = cw_enc;
                end
            end
            WR_LO: begin
                mem_addr  = dst_a;
                mem_wen   = 1'b1;
                mem_wdata = res_q[7:0];
                state_d   = WR_HI;
            end
            WR_HI: begin
                mem_addr  = dst_a + ADDR_W'(1);
                mem_wen   = 1'b1;
                mem_wdata = res_q[15:8];
                if (idx_q < 8'(N_MSG - 1)) begin
                    idx_d   = idx_q + 8'd1;
                    state_d = RD_LO;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            lo_q    <= '0;
            res_q   <= '0;
            sec_q   <= '0;
            ded_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            sec_q   <= sec_d;
            ded_q   <= ded_d;
            done_q  <= done_d;
        end
    end

    assign done    = done_q;
    assign sec_cnt = sec_q;
    assign ded_cnt = ded_q;

endmodule

// File: tb/tb_hamming_mem_engine.sv
// Directed bench for hamming_mem_engine with a one-cycle-latency memory.
// Covers encode, decode (clean/SEC/DED), busy req, and mid-run reset.
module tb_hamming_mem_engine;

    localparam int N   = 15;
    localparam int SRC = 0;
    localparam int DST = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       mode = 1'b0;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_wen;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] sec_cnt;
    logic [7:0] ded_cnt;

    logic [7:0] src_mem [256];
    logic [7:0] dst_mem [256];
    logic [7:0] rdata_q = 8'h00;

    int npass = 0;
    int ntot  = 0;

    hamming_mem_engine #(
        .N_MSG(N), .SRC_BASE(SRC), .DST_BASE(DST), .ADDR_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
        .done(done), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdata_q <= src_mem[mem_addr];
        if (mem_wen) dst_mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = rdata_q;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference encoder built from parity masks over the data positions.
    function automatic logic [15:0] ref_enc(input logic [10:0] d);
        int          pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        logic [15:0] c;
        logic [15:0] dc;
        c = '0;
        for (int i = 0; i < 11; i++) c[pos[i]] = d[i];
        dc   = c;
        c[1] = ^(dc & 16'hAAAA);
        c[2] = ^(dc & 16'hCCCC);
        c[4] = ^(dc & 16'hF0F0);
        c[8] = ^(dc & 16'hFF00);
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [15:0] dst_word(input int i);
        return {dst_mem[DST + 2*i + 1], dst_mem[DST + 2*i]};
    endfunction

    task automatic load_word(input int i, input logic [15:0] w);
        src_mem[SRC + 2*i]     = w[7:0];
        src_mem[SRC + 2*i + 1] = w[15:8];
    endtask

    // Accept a req, then count edges until done (bounded at 200).
    task automatic run(input logic m, input int busy_at, output int cyc);
        @(negedge clk);
        req  = 1'b1;
        mode = m;
        @(posedge clk);
        #1;
        req = 1'b0;
        chk("done_clr", 16'(done), 16'h0);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == busy_at) begin
                req  = 1'b1;
                mode = ~m;
            end
            if (cyc == busy_at + 1) req = 1'b0;
        end
    endtask

    logic [10:0] dv     [N];
    logic [15:0] enc_w  [N];
    logic [15:0] dir_cw [N];
    logic [15:0] dir_rs [N];
    logic [15:0] w;
    logic [15:0] exp_w;
    int          nf [N];
    int          a, b, cyc, esec, eded;

    initial begin
        for (int i = 0; i < 256; i++) src_mem[i] = 8'h00;
        for (int i = 0; i < N; i++) begin
            dir_cw[i] = 16'h0000;
            dir_rs[i] = 16'h0000;
        end
        dir_cw[0] = 16'hFFDF; dir_rs[0] = 16'h47FF;
        dir_cw[1] = 16'hFFFE; dir_rs[1] = 16'h47FF;
        dir_cw[2] = 16'hFFFF; dir_rs[2] = 16'h07FF;
        dir_cw[3] = 16'hFDDF; dir_rs[3] = 16'h87ED;

        // Reset state
        #12;
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_wen", 16'(mem_wen), 16'h0);
        chk("rst_addr", 16'(mem_addr), 16'(SRC));
        chk("rst_sec", 16'(sec_cnt), 16'h0);
        chk("rst_ded", 16'(ded_cnt), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Encode with a busy req (and mode toggle) at cycle 20
        dv[0] = 11'h000;
        dv[1] = 11'h001;
        dv[2] = 11'h7FF;
        for (int i = 3; i < N; i++) dv[i] = 11'($urandom);
        for (int i = 0; i < N; i++) begin
            load_word(i, {5'b0, dv[i]});
            enc_w[i] = ref_enc(dv[i]);
        end
        run(1'b0, 20, cyc);
        chk("enc_cycles", 16'(cyc), 16'd76);
        chk("enc_m0", dst_word(0), 16'h0000);
        chk("enc_m1", dst_word(1), 16'h000F);
        chk("enc_m2", dst_word(2), 16'hFFFF);
        for (int i = 3; i < N; i++)
            chk($sformatf("enc_m%0d", i), dst_word(i), enc_w[i]);
        chk("enc_sec", 16'(sec_cnt), 16'h0);
        chk("enc_ded", 16'(ded_cnt), 16'h0);

        // Directed decode
        for (int i = 0; i < N; i++) load_word(i, dir_cw[i]);
        run(1'b1, 0, cyc);
        chk("dec_cycles", 16'(cyc), 16'd76);
        for (int i = 0; i < N; i++)
            chk($sformatf("dec_m%0d", i), dst_word(i), dir_rs[i]);
        chk("dec_sec", 16'(sec_cnt), 16'd2);
        chk("dec_ded", 16'(ded_cnt), 16'd1);

        // Random 0/1/2 bit flips on the encoded words
        esec = 0;
        eded = 0;
        for (int i = 0; i < N; i++) begin
            nf[i] = int'($urandom_range(0, 2));
            a = int'($urandom_range(0, 15));
            do b = int'($urandom_range(0, 15)); while (b == a);
            w = enc_w[i];
            if (nf[i] >= 1) w[a] = ~w[a];
            if (nf[i] == 2) w[b] = ~w[b];
            if (nf[i] == 1) esec++;
            if (nf[i] == 2) eded++;
            load_word(i, w);
        end
        run(1'b1, 0, cyc);
        chk("rnd_cycles", 16'(cyc), 16'd76);
        for (int i = 0; i < N; i++) begin
            if (nf[i] == 2) begin
                w = dst_word(i);
                chk($sformatf("rnd_ded_m%0d", i), 16'(w[15:11]), 16'h10);
            end else begin
                exp_w = {(nf[i] == 1) ? 2'b01 : 2'b00, 3'b000, dv[i]};
                chk($sformatf("rnd_m%0d", i), dst_word(i), exp_w);
            end
        end
        chk("rnd_sec", 16'(sec_cnt), 16'(esec));
        chk("rnd_ded", 16'(ded_cnt), 16'(eded));

        // Reset during message 3 (WR_LO) of an encode run
        for (int i = 0; i < N; i++) load_word(i, {5'b0, dv[i]});
        @(negedge clk);
        req  = 1'b1;
        mode = 1'b0;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        chk("mid_wen", 16'(mem_wen), 16'h1);
        chk("mid_addr", 16'(mem_addr), 16'(DST + 6));
        rst_n = 1'b0;
        #1;
        chk("ar_done", 16'(done), 16'h0);
        chk("ar_wen", 16'(mem_wen), 16'h0);
        chk("ar_addr", 16'(mem_addr), 16'(SRC));
        @(negedge clk);
        rst_n = 1'b1;
        chk("ar_enc_m2", dst_word(2), 16'hFFFF);

        // Fresh decode run after the abort
        for (int i = 0; i < N; i++) load_word(i, dir_cw[i]);
        run(1'b1, 0, cyc);
        chk("fr_cycles", 16'(cyc), 16'd76);
        for (int i = 0; i < N; i++)
            chk($sformatf("fr_m%0d", i), dst_word(i), dir_rs[i]);
        chk("fr_sec", 16'(sec_cnt), 16'd2);
        chk("fr_ded", 16'(ded_cnt), 16'd1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
